serial_neg_arb: RTL and testbench
=================================

SERIAL_NEG_ARB -- requirements
Module: serial_neg_arb

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 t_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 r  input  1  reset, synchronous, active-high.
REQ-004 a_valid  input  1  requester A holds a word.
REQ-005 a_data  input  WIDTH  requester A operand, two's-complement.
REQ-006 a_ready  output  1  A's word accepted this cycle when a_valid=1.
REQ-007 b_valid  input  1  requester B holds a word.
REQ-008 b_data  input  WIDTH  requester B operand, two's-complement.
REQ-009 b_ready  output  1  B's word accepted this cycle when b_valid=1.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_data  output  WIDTH  two's complement (negation) of the accepted word.
REQ-013 out_src  output  1  source of the result: 0=A, 1=B.
REQ-014 out_ovf  output  1  accepted word was the most-negative value (1 followed by WIDTH-1 zeros).
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, SHIFT, DONE; only these transitions: IDLE->SHIFT on acceptance, SHIFT->DONE after WIDTH bits, DONE->IDLE on out_valid&&out_ready.
REQ-017 Arbitration in IDLE: one valid requester gets its ready; both valid means the requester not granted last; last_grant updates only on acceptance.
REQ-018 a_ready/b_ready are combinational and never high together; both are low in SHIFT and DONE.
REQ-019 Acceptance edge loads operand into shift register, clears bit counter and seen_one flag, latches source id and out_ovf flag.
REQ-020 Each SHIFT edge processes the LSB: result bit = bit XOR seen_one; seen_one |= bit; result shifts in from MSB; operand shifts right.
REQ-021 SHIFT lasts exactly WIDTH edges; the edge that processes bit WIDTH-1 also enters DONE.
REQ-022 Latency: out_valid is high WIDTH edges after the acceptance edge.
REQ-023 In DONE, out_valid=1, and out_data/out_src/out_ovf stay stable until the handshake edge.
REQ-024 Minimum interval between acceptances is WIDTH+2 edges; no acceptance on the DONE->IDLE edge.
REQ-025 Arithmetic is modulo 2^WIDTH: input 0 yields 0 with out_ovf=0; most-negative input yields itself with out_ovf=1.
REQ-026 out_valid=0 outside DONE; out_data holds its last value outside DONE.

Reset
REQ-027 r=1 at an edge forces state IDLE, out_valid=0, out_data=0, out_src=0, out_ovf=0, busy=0, counter=0, seen_one=0, last_grant=B (so A wins first contention).
REQ-028 Reset during SHIFT or DONE discards the word in flight; no result is emitted for it.
REQ-029 While r=1, a_ready and b_ready are 0.

Structure
REQ-030 Shared package serial_neg_pkg holds the FSM state enum, SRC_A/SRC_B constants, and the WIDTH default.
REQ-031 Sub-module serial_cmpl_bit holds the per-bit complement stage (seen_one flop, XOR, synchronous clear on load or r); it is instantiated once.
REQ-032 All flops are in t_clk domain; no latches or combinational loops.

Verification
REQ-033 WIDTH=8, A sends 0x05 alone -> a_ready pulses once; out_valid at +8 edges; out_data=0xFB, out_src=0, out_ovf=0.
REQ-034 A=0x01 and B=0x02 valid together from reset -> A served first (0xFF, src 0), then B (0xFE, src 1); B's ready is never high during A's job.
REQ-035 A sends 0x80 -> out_data=0x80, out_ovf=1; A sends 0x00 -> out_data=0x00, out_ovf=0.
REQ-036 out_ready held low 5 cycles in DONE for input 0x3C -> out_data=0xC4 stable throughout; IDLE follows the handshake edge; next acceptance no earlier than the edge after.
REQ-037 r asserted on the 4th SHIFT edge of 0x55 -> out_valid never rises for it; next word 0x01 yields 0xFF.
REQ-038 Randomized A/B traffic, 1000 words -> each result equals (-x) mod 256 with the correct source; no starvation under continuous dual requests (strict alternation).

Source files
------------

// File: rtl/serial_neg_pkg.sv
// serial_neg_arb shared definitions.
// State encodings, source ids and default word width.
package serial_neg_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/serial_neg_arb_if.sv
// serial_neg_arb handshake bundle.
// Two requesters, one result consumer, plus busy.
interface serial_neg_arb_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ovf;
    logic             busy;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data,
        input  out_src, out_ovf, busy
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data,
        output out_src, out_ovf, busy
    );
endinterface

// File: rtl/serial_cmpl_bit.sv
// Bit-serial two's complement stage.
// Copies bits up to the first 1, inverts the rest.
module serial_cmpl_bit (
    input  logic clk,
    input  logic r,
    input  logic load,
    input  logic en,
    input  logic bit_in,
    output logic res_bit
);
    logic seen_one;

    // remember whether a 1 has been passed in this word
    always_ff @(posedge clk) begin
        if (r || load) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | bit_in;
        end
    end

    assign res_bit = bit_in ^ seen_one;
endmodule

// File: rtl/serial_neg_arb.sv
// Two-requester round-robin bit-serial negator.
// One word in flight; result held until consumed.
module serial_neg_arb
    import serial_neg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic          t_clk,
    input logic          r,
    serial_neg_arb_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             last_grant;
    logic [WIDTH-1:0] data_q;
    logic             src_q;
    logic             ovf_q;

    logic             idle;
    logic             grant_a;
    logic             grant_b;
    logic             acc;
    logic             sel_src;
    logic [WIDTH-1:0] sel_data;
    logic             shift_en;
    logic             last_bit;
    logic             res_bit;

    // arbitration: alternate on contention, nothing granted in reset
    always_comb begin
        idle     = (state == ST_IDLE) && !r;
        grant_a  = idle && bus.a_valid
                   && (!bus.b_valid || last_grant == SRC_B);
        grant_b  = idle && bus.b_valid
                   && (!bus.a_valid || last_grant == SRC_A);
        acc      = grant_a || grant_b;
        sel_src  = grant_b ? SRC_B : SRC_A;
        sel_data = grant_b ? bus.b_data : bus.a_data;
        shift_en = (state == ST_SHIFT);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    serial_cmpl_bit u_bit (
        .clk    (t_clk),
        .r      (r),
        .load   (acc),
        .en     (shift_en),
        .bit_in (opnd[0]),
        .res_bit(res_bit)
    );

    // control FSM and datapath; result bits refill the operand from the top
    always_ff @(posedge t_clk) begin
        if (r) begin
            state      <= ST_IDLE;
            opnd       <= '0;
            cnt        <= '0;
            last_grant <= SRC_B;
            data_q     <= '0;
            src_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (acc) begin
                        opnd       <= sel_data;
                        cnt        <= '0;
                        src_q      <= sel_src;
                        ovf_q      <= (sel_data == MOST_NEG);
                        last_grant <= sel_src;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    opnd <= {res_bit, opnd[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        data_q <= {res_bit, opnd[WIDTH-1:1]};
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_serial_neg_arb.sv
// Testbench for serial_neg_arb, WIDTH=8.
// Directed steps plus random traffic against a result scoreboard.
module tb_serial_neg_arb;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       o;
    } exp_t;

    logic clk;
    logic r;

    serial_neg_arb_if #(.WIDTH(8)) bus ();

    serial_neg_arb #(.WIDTH(8)) dut (
        .t_clk(clk),
        .r    (r),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t hist[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edges = 0;
    int   outs = 0;
    int   acc_edge = 0;
    int   fv_edge = 0;
    int   a_pulses = 0;
    int   ov_rise = 0;
    logic model_last = 1'b1;
    logic prev_ov = 1'b0;
    logic saw_acc_a = 1'b0;
    logic saw_acc_b = 1'b0;
    logic [7:0] last_d = '0;
    logic last_s = 1'b0;
    logic last_o = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: sample at negedge, then step past the rising edge
    task automatic cyc();
        logic       s;
        logic [7:0] d;
        logic [7:0] nd;
        exp_t       e;
        @(negedge clk);
        saw_acc_a = 1'b0;
        saw_acc_b = 1'b0;
        if (bus.a_ready) a_pulses++;
        if (bus.out_valid && !prev_ov) begin
            fv_edge = edges;
            ov_rise++;
        end
        prev_ov = bus.out_valid;
        chk("ready_excl", 32'(bus.a_ready & bus.b_ready), 0);
        if (r) begin
            chk("ready_in_reset", 32'(bus.a_ready | bus.b_ready), 0);
            sb.delete();
            model_last = 1'b1;
        end else begin
            if (bus.busy)
                chk("ready_busy", 32'(bus.a_ready | bus.b_ready), 0);
            if ((bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready)) begin
                s = bus.b_ready;
                d = s ? bus.b_data : bus.a_data;
                if (bus.a_valid && bus.b_valid)
                    chk("alternate", 32'(s), 32'(!model_last));
                model_last = s;
                nd = 8'd0 - d;
                sb.push_back('{d: nd, s: s, o: (d == 8'h80)});
                acc_edge = edges + 1;
                saw_acc_a = !s;
                saw_acc_b = s;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_src", 32'(bus.out_src), 32'(e.s));
                    chk("out_ovf", 32'(bus.out_ovf), 32'(e.o));
                end
                last_d = bus.out_data;
                last_s = bus.out_src;
                last_o = bus.out_ovf;
                hist.push_back('{d: bus.out_data, s: bus.out_src, o: bus.out_ovf});
                outs++;
            end
        end
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic run_until_out(input int o0, input int max);
        int n = 0;
        while (outs == o0 && n < max) begin
            cyc();
            n++;
        end
        chk("out_timeout", 32'(outs != o0), 1);
    endtask

    task automatic send_one(input logic s, input logic [7:0] d);
        int n = 0;
        int o0 = outs;
        bus.out_ready = 1'b1;
        if (s) begin
            bus.b_valid = 1'b1;
            bus.b_data  = d;
        end else begin
            bus.a_valid = 1'b1;
            bus.a_data  = d;
        end
        do begin
            cyc();
            n++;
        end while (!(saw_acc_a || saw_acc_b) && n < 30);
        chk("send_acc", 32'(saw_acc_a | saw_acc_b), 1);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        run_until_out(o0, 30);
    endtask

    initial begin
        int n;
        int o0;
        r             = 1'b1;
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h33;
        bus.b_valid   = 1'b0;
        bus.b_data    = '0;
        bus.out_ready = 1'b0;

        // reset with A requesting: no ready, cleared outputs
        repeat (3) cyc();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_src", 32'(bus.out_src), 0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        bus.a_valid = 1'b0;
        r = 1'b0;
        cyc();

        // single word from A, latency and one ready pulse
        a_pulses = 0;
        send_one(1'b0, 8'h05);
        chk("a_pulses", 32'(a_pulses), 1);
        chk("latency", 32'(fv_edge - acc_edge), 8);
        chk("neg05_data", 32'(last_d), 32'hFB);
        chk("neg05_src", 32'(last_s), 0);
        chk("neg05_ovf", 32'(last_o), 0);

        // contention from reset: A then B
        r = 1'b1;
        repeat (2) cyc();
        r = 1'b0;
        hist.delete();
        bus.out_ready = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h01;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h02;
        o0 = outs;
        n = 0;
        while (outs - o0 < 2 && n < 60) begin
            cyc();
            if (saw_acc_a) bus.a_valid = 1'b0;
            if (saw_acc_b) bus.b_valid = 1'b0;
            n++;
        end
        chk("dual_count", 32'(hist.size()), 2);
        if (hist.size() >= 2) begin
            chk("dual_first_d", 32'(hist[0].d), 32'hFF);
            chk("dual_first_s", 32'(hist[0].s), 0);
            chk("dual_second_d", 32'(hist[1].d), 32'hFE);
            chk("dual_second_s", 32'(hist[1].s), 1);
        end

        // most-negative and zero
        send_one(1'b0, 8'h80);
        chk("neg80_data", 32'(last_d), 32'h80);
        chk("neg80_ovf", 32'(last_o), 1);
        send_one(1'b0, 8'h00);
        chk("neg00_data", 32'(last_d), 32'h00);
        chk("neg00_ovf", 32'(last_o), 0);

        // backpressure in DONE, next word waiting
        bus.out_ready = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h3C;
        cyc();
        chk("bp_acc", 32'(saw_acc_a), 1);
        bus.a_data = 8'h11;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("bp_valid", 32'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_stable_d", 32'(bus.out_data), 32'hC4);
            chk("bp_stable_v", 32'(bus.out_valid), 1);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("no_acc_on_done", 32'(bus.a_ready), 0);
        o0 = outs;
        cyc();
        chk("bp_handshake", 32'(outs - o0), 1);
        chk("bp_data", 32'(last_d), 32'hC4);
        chk("bp_idle", 32'(bus.busy), 0);
        cyc();
        chk("bp_next_acc", 32'(saw_acc_a), 1);
        bus.a_valid = 1'b0;
        run_until_out(o0 + 1, 30);
        chk("bp_next_data", 32'(last_d), 32'hEF);

        // reset on the 4th shift edge discards the word
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h55;
        cyc();
        chk("rst_mid_acc", 32'(saw_acc_a), 1);
        bus.a_valid = 1'b0;
        repeat (3) cyc();
        r = 1'b1;
        cyc();
        r = 1'b0;
        ov_rise = 0;
        repeat (15) cyc();
        chk("rst_mid_no_out", 32'(ov_rise), 0);
        chk("rst_mid_idle", 32'(bus.busy), 0);
        send_one(1'b0, 8'h01);
        chk("rst_mid_next", 32'(last_d), 32'hFF);

        // continuous dual requests: strict alternation
        bus.out_ready = 1'b1;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_data  = 8'($urandom);
        bus.b_data  = 8'($urandom);
        hist.delete();
        n = 0;
        while (hist.size() < 40 && n < 2000) begin
            cyc();
            if (saw_acc_a) bus.a_data = 8'($urandom);
            if (saw_acc_b) bus.b_data = 8'($urandom);
            n++;
        end
        chk("alt_count", 32'(hist.size()), 40);
        for (int i = 1; i < hist.size(); i++)
            chk("alt_src", 32'(hist[i].s), 32'(!hist[i-1].s));
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (12) cyc();

        // random traffic, 1000 words
        o0 = outs;
        n = 0;
        while (outs - o0 < 1000 && n < 40000) begin
            if (!bus.a_valid && $urandom_range(0, 1) == 1) begin
                bus.a_valid = 1'b1;
                bus.a_data  = 8'($urandom);
            end
            if (!bus.b_valid && $urandom_range(0, 1) == 1) begin
                bus.b_valid = 1'b1;
                bus.b_data  = 8'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (saw_acc_a) bus.a_valid = 1'b0;
            if (saw_acc_b) bus.b_valid = 1'b0;
            n++;
        end
        chk("rand_words", 32'(outs - o0 >= 1000), 1);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) cyc();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
